// File: rtl/bch_pkg.sv
// Shared BCH(63,24) constants and GF(2^6) arithmetic helpers.
// Also used by bch_encode for N, K and PRIM_POLY.
package bch_pkg;

    localparam int unsigned N        = 63;
    localparam int unsigned K        = 24;
    localparam int unsigned T        = 7;
    localparam int unsigned M        = 6;
    localparam int unsigned NUM_SYND = 2 * T;
    localparam int unsigned SYND_W   = NUM_SYND * M;
    localparam int unsigned CNT_W    = $clog2(N + 1);

    localparam logic [M:0] PRIM_POLY = 7'b1000011;

    typedef logic [M-1:0] gf_elem_t;

    // alpha^e for e = 0..2T, entry e at bits [e*M +: M]
    localparam logic [(NUM_SYND+1)*M-1:0] ALPHA_POW = {
        6'h14, 6'h0A, 6'h05, 6'h23, 6'h30, 6'h18, 6'h0C, 6'h06,
        6'h03, 6'h20, 6'h10, 6'h08, 6'h04, 6'h02, 6'h01
    };

    // General GF(2^M) product: carry-less multiply then reduce by PRIM_POLY.
    function automatic gf_elem_t gf_mul(input gf_elem_t a, input gf_elem_t b);
        logic [2*M-2:0] prod;
        prod = '0;
        for (int unsigned i = 0; i < M; i++) begin
            if (b[i]) begin
                prod = prod ^ ((2*M-1)'(a) << i);
            end
        end
        for (int i = 2 * int'(M) - 2; i >= int'(M); i--) begin
            if (prod[i]) begin
                prod = prod ^ ((2*M-1)'(PRIM_POLY) << (i - int'(M)));
            end
        end
        return prod[M-1:0];
    endfunction

    // Multiply by the constant alpha^e; folds to an XOR network when e is static.
    function automatic gf_elem_t gf_mul_alpha_pow(input gf_elem_t a, input int unsigned e);
        return gf_mul(a, ALPHA_POW[e*M +: M]);
    endfunction

endpackage

// File: rtl/gf_horner_cell.sv
// One syndrome accumulator: S <= S*alpha^EXP ^ r per consumed bit, or S <= r on frame start.
// Exposes the next accumulator value so the top can capture a completed frame on the last edge.
module gf_horner_cell
    import bch_pkg::*;
#(
    parameter int unsigned EXP = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_bit,
    input  logic         i_load,
    input  logic         i_shift,
    output logic [M-1:0] o_acc_nxt_c
);

    logic [M-1:0] r_acc;
    logic [M-1:0] w_acc_nxt;

    always_comb begin
        w_acc_nxt = r_acc;
        if (i_load) begin
            w_acc_nxt = M'(i_bit);
        end else if (i_shift) begin
            w_acc_nxt = gf_mul_alpha_pow(r_acc, EXP) ^ M'(i_bit);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_nxt;
        end
    end

    assign o_acc_nxt_c = w_acc_nxt;

endmodule

// File: rtl/bch_syndrome.sv
// Serial BCH(63,24) syndrome generator over GF(2^6), one codeword bit per valid cycle.
// Define BCH_EVEN_SYND_EN to compute even syndromes too; otherwise only odd S_j are produced.
module bch_syndrome
    import bch_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_data_in,
    input  logic              i_data_valid,
    output logic [SYND_W-1:0] o_synd,
    output logic              o_synd_valid,
    output logic              o_err_detect,
    output logic              o_busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

`ifdef BCH_EVEN_SYND_EN
    localparam bit EVEN_EN = 1'b1;
`else
    localparam bit EVEN_EN = 1'b0;
`endif

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [SYND_W-1:0] r_synd;
    logic              r_synd_valid;
    logic              r_err_detect;
    logic              w_load;
    logic              w_shift;
    logic              w_last;
    logic [SYND_W-1:0] w_synd_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-bit strobes; the N-th consumed bit closes the frame.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_data_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (i_data_valid) begin
                    w_shift = 1'b1;
                    if (r_cnt == CNT_W'(N - 1)) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    for (genvar j = 1; j <= NUM_SYND; j++) begin : g_synd
        if (EVEN_EN || (j % 2 == 1)) begin : g_cell
            gf_horner_cell #(
                .EXP(j)
            ) u_cell (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_bit      (i_data_in),
                .i_load     (w_load),
                .i_shift    (w_shift),
                .o_acc_nxt_c(w_synd_nxt[j*M-1 -: M])
            );
        end else begin : g_tied
            assign w_synd_nxt[j*M-1 -: M] = '0;
        end
    end

    // Bit counter and result registers; results hold until the next frame completes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_synd       <= '0;
            r_synd_valid <= 1'b0;
            r_err_detect <= 1'b0;
        end else begin
            r_synd_valid <= w_last;
            if (w_load) begin
                r_cnt <= CNT_W'(1);
            end else if (w_shift) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_last) begin
                r_synd       <= w_synd_nxt;
                r_err_detect <= |w_synd_nxt;
            end
        end
    end

    assign o_synd       = r_synd;
    assign o_synd_valid = r_synd_valid;
    assign o_err_detect = r_err_detect;
    assign o_busy       = (r_state == ST_ACCUM);

endmodule

// File: tb/tb_bch_syndrome.sv
// Self-checking bench for bch_syndrome: directed frames plus randomized frames against
// a syndrome model evaluated directly as S_j = sum r_i * alpha^(j*i).
module tb_bch_syndrome;

    localparam int NB = 63;
    localparam int MB = 6;
    localparam int NS = 14;
    localparam int SW = NS * MB;

`ifdef BCH_EVEN_SYND_EN
    localparam bit EVEN_EN = 1'b1;
`else
    localparam bit EVEN_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          din;
    logic          dv;
    logic [SW-1:0] synd;
    logic          sv;
    logic          err;
    logic          busy;

    always #5 clk = ~clk;

    bch_syndrome dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data_in   (din),
        .i_data_valid(dv),
        .o_synd      (synd),
        .o_synd_valid(sv),
        .o_err_detect(err),
        .o_busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // GF(64) antilog/log tables built from x^6 = x + 1
    int exp_t[0:62];
    int log_t[0:63];

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 63];
    endfunction

    logic [39:0] gpoly;

    function automatic logic [SW-1:0] model_synd(input logic [NB-1:0] cw);
        logic [SW-1:0] r;
        int s;
        r = '0;
        for (int j = 1; j <= NS; j++) begin
            s = 0;
            if (EVEN_EN || (j % 2 == 1)) begin
                for (int i = 0; i < NB; i++) begin
                    if (cw[i]) s = s ^ exp_t[(j * i) % 63];
                end
            end
            r[(j-1)*MB +: MB] = 6'(s);
        end
        return r;
    endfunction

    function automatic logic [NB-1:0] encode(input logic [23:0] msg);
        logic [NB-1:0] p;
        p = {msg, 39'b0};
        for (int i = NB - 1; i >= 39; i--) begin
            if (p[i]) p[i -: 40] = p[i -: 40] ^ gpoly;
        end
        return {msg, p[38:0]};
    endfunction

    // Scoreboard / monitor state
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] last_exp = '0;
    logic [SW-1:0] cur_exp;
    bit            mon_en   = 1'b0;
    bit            exp_busy = 1'b0;
    int            pulses   = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (sv) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    chk("spurious_pulse", 1, 0);
                end else begin
                    cur_exp  = exp_q.pop_front();
                    last_exp = cur_exp;
                    chk("synd", synd, cur_exp);
                    chk("err", err, |cur_exp);
                end
            end else begin
                chk("synd_hold", synd, last_exp);
                chk("err_hold", err, |last_exp);
            end
            chk("busy", busy, exp_busy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends the first nbits of cw (MSB first); a full frame queues its expected syndromes.
    task automatic drive_frame(input logic [NB-1:0] cw, input int nbits,
                               input logic [NB-1:0] stall_mask, input int stall_len,
                               output int edges);
        edges = 0;
        for (int k = 0; k < nbits; k++) begin
            dv  = 1'b1;
            din = cw[NB-1-k];
            tick();
            edges++;
            exp_busy = (k < NB - 1);
            if (k == NB - 1) exp_q.push_back(model_synd(cw));
            if (stall_mask[k] && k < NB - 1) begin
                dv = 1'b0;
                repeat (stall_len) begin
                    tick();
                    edges++;
                end
            end
        end
        dv = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int            v;
        int            g[0:39];
        int            deg;
        bit            root[0:62];
        int            k;
        int            edges;
        int            p0;
        logic [NB-1:0] cw;
        logic [63:0]   rnd;
        logic [NB-1:0] mask;

        v = 1;
        log_t[0] = 0;
        for (int i = 0; i < 63; i++) begin
            exp_t[i] = v;
            log_t[v] = i;
            v = v << 1;
            if (v >= 64) v = v ^ 'h43;
        end
        // generator = product of (x + alpha^k) over the cosets of 1,3,...,13
        for (int i = 0; i < 63; i++) root[i] = 1'b0;
        for (int i = 1; i <= 13; i += 2) begin
            k = i;
            repeat (6) begin
                root[k] = 1'b1;
                k = (k * 2) % 63;
            end
        end
        for (int d = 0; d < 40; d++) g[d] = 0;
        g[0] = 1;
        deg  = 0;
        for (int r = 0; r < 63; r++) begin
            if (root[r]) begin
                for (int d = deg + 1; d >= 0; d--) begin
                    g[d] = ((d > 0) ? g[d-1] : 0) ^ gmul(g[d], exp_t[r]);
                end
                deg++;
            end
        end
        for (int d = 0; d < 40; d++) gpoly[d] = g[d][0];

        rst = 1'b1;
        dv  = 1'b0;
        din = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_synd", synd, 0);
        chk("rst_sv", sv, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        mon_en = 1'b1;

        // all-zero frame: pulse exactly after the 63rd edge, one cycle wide
        drive_frame('0, NB, '0, 0, edges);
        chk("zero_edges", edges, 63);
        chk("zero_pulse", sv, 1);
        tick();
        chk("zero_pulse_end", sv, 0);
        chk("zero_err", err, 0);

        // encoded codeword of 1010... message
        drive_frame(encode(24'hAAAAAA), NB, '0, 0, edges);
        chk("cw_pulse", sv, 1);
        chk("cw_synd", synd, 0);
        chk("cw_err", err, 0);
        repeat (2) tick();

        // first bit flipped
        cw = '0;
        cw[NB-1] = 1'b1;
        drive_frame(cw, NB, '0, 0, edges);
        chk("first_s1", synd[5:0], 6'h21);
        chk("first_s2", synd[11:6], EVEN_EN ? 6'h31 : 6'h00);
        chk("first_err", err, 1);
        repeat (2) tick();

        // last bit flipped
        cw = '0;
        cw[0] = 1'b1;
        drive_frame(cw, NB, '0, 0, edges);
        for (int j = 1; j <= NS; j++) begin
            chk($sformatf("last_s%0d", j), synd[(j-1)*MB +: MB],
                (EVEN_EN || (j % 2 == 1)) ? 6'h01 : 6'h00);
        end
        chk("last_err", err, 1);
        repeat (2) tick();

        // first bit flipped with 3-cycle stalls after bits 10 and 40
        cw = '0;
        cw[NB-1] = 1'b1;
        mask = '0;
        mask[9]  = 1'b1;
        mask[39] = 1'b1;
        drive_frame(cw, NB, mask, 3, edges);
        chk("stall_edges", edges, 69);
        chk("stall_pulse", sv, 1);
        chk("stall_s1", synd[5:0], 6'h21);
        repeat (2) tick();

        // reset mid-frame (with data_valid high on the reset edge), then zero + back-to-back frame
        drive_frame('1, 30, '0, 0, edges);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        dv  = 1'b1;
        din = 1'b1;
        tick();
        rst = 1'b0;
        dv  = 1'b0;
        last_exp = '0;
        exp_busy = 1'b0;
        chk("abort_synd", synd, 0);
        chk("abort_busy", busy, 0);
        p0 = pulses;
        drive_frame('0, NB, '0, 0, edges);
        cw = '0;
        cw[NB-1] = 1'b1;
        drive_frame(cw, NB, '0, 0, edges);
        tick();
        chk("b2b_pulses", pulses - p0, 2);
        chk("b2b_s1", synd[5:0], 6'h21);
        repeat (2) tick();

        // randomized frames: raw bits, codewords, codewords with a few errors
        for (int f = 0; f < 24; f++) begin
            case ($urandom_range(0, 3))
                0: begin
                    rnd = {$urandom, $urandom};
                    cw  = rnd[NB-1:0];
                end
                1: cw = encode(24'($urandom));
                2: begin
                    cw = encode(24'($urandom));
                    repeat ($urandom_range(1, 3)) cw[$urandom_range(0, NB - 1)] ^= 1'b1;
                end
                default: begin
                    cw = '0;
                    repeat ($urandom_range(1, 7)) cw[$urandom_range(0, NB - 1)] ^= 1'b1;
                end
            endcase
            rnd  = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            mask = rnd[NB-1:0];
            drive_frame(cw, NB, mask, $urandom_range(0, 2), edges);
            chk("rnd_pulse", sv, 1);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        chk("pending", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bch_syndrome.md
BCH_SYNDROME -- requirements
Module: bch_syndrome

Interface
REQ-001 Parameter N, 63, codeword length in bits.
REQ-002 Parameter K, 24, message length in bits.
REQ-003 Parameter T, 7, correctable errors; 2T syndromes.
REQ-004 Parameter M, 6, Galois field degree, GF(2^M).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 data_in  input  1  serial received codeword bit, first bit = coefficient of x^(N-1).
REQ-008 data_valid  input  1  data_in is consumed on every rising edge where data_valid=1.
REQ-009 synd  output  2*T*M  syndromes packed S_j in bits [j*M-1 -: M], j=1..2T (S1 at [5:0]).
REQ-010 synd_valid  output  1  one-cycle pulse: synd holds a completed frame.
REQ-011 err_detect  output  1  OR-reduction of synd, qualified by synd_valid.
REQ-012 busy  output  1  high while a frame is partially received.

Function
REQ-013 Field: GF(2^6), primitive polynomial x^6+x+1, alpha = 6'b000010.
REQ-014 Per syndrome j, each consumed bit r updates S_j <= S_j*alpha^j XOR r (Horner, constant multiplier).
REQ-015 FSM states IDLE, ACCUM; IDLE->ACCUM on first consumed bit; ACCUM->IDLE on consumption of the N-th bit.
REQ-016 First bit of a frame loads S_j <= r (prior contents discarded); bit counter set to 1.
REQ-017 data_valid=0 in ACCUM stalls: accumulators and counter hold, no timeout.
REQ-018 synd_valid SHALL be 1 in the cycle immediately after the edge consuming the N-th bit, then 0.
REQ-019 synd and err_detect SHALL hold their values from synd_valid until the next frame completes.
REQ-020 err_detect = 1 only if any S_j != 0 for the completed frame; 0 otherwise.
REQ-021 data_valid=1 in the same cycle synd_valid is high starts the next frame (back-to-back, zero bubble).
REQ-022 Bit counter width = clog2(N+1); counter never exceeds N.
REQ-023 busy = 1 exactly in ACCUM.

Reset
REQ-024 rst=1 at a rising edge: state IDLE, counter 0, all S_j 0, synd 0, synd_valid 0, err_detect 0, busy 0.
REQ-025 rst mid-frame discards the partial frame; no synd_valid pulse for it.
REQ-026 rst takes priority over data_valid in the same cycle.

Configuration
REQ-027 Macro BCH_EVEN_SYND_EN defined: all 2T syndromes computed (even syndromes via Horner with alpha^(2i)).
REQ-028 Macro undefined: only odd S_j computed; even-syndrome fields of synd tied to 0; err_detect uses odd syndromes only.

Structure
REQ-029 Package bch_pkg holds N, K, T, M, PRIM_POLY (7'b1000011), alpha-power constant table, and the constant-multiply function.
REQ-030 One sub-module gf_horner_cell (one syndrome accumulator, multiplier exponent as parameter), instantiated per computed syndrome.
REQ-031 bch_pkg is shared with bch_encode for N, K, PRIM_POLY.

Verification
REQ-032 63 zero bits contiguous -> synd_valid one pulse at cycle after 63rd bit, synd=0, err_detect=0.
REQ-033 bch_encode output for message 101010101010101010101010 (24 data then 39 parity) -> synd=0, err_detect=0.
REQ-034 All-zero codeword, first bit flipped -> S1=6'h21, err_detect=1; with BCH_EVEN_SYND_EN S2=6'h31, without S2=0.
REQ-035 All-zero codeword, last bit flipped -> every computed S_j=6'h01, err_detect=1.
REQ-036 Same as REQ-034 with data_valid low for 3 cycles after bits 10 and 40 -> identical synd, pulse delayed by 6 cycles.
REQ-037 rst after 30 bits, then zero frame, then back-to-back REQ-034 frame -> exactly two synd_valid pulses, second with S1=6'h21.
